// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the core and the host/DMA port.
package dram_arb_pkg;

    typedef enum logic [1:0] {RSP_NONE, RSP_CORE, RSP_HOST} rsp_t;

    localparam int MAXWAIT_DEFAULT = 4;
    localparam int WAITCNT_W       = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of cycles a host request has been blocked; expired hands the host priority.
module arb_starve_counter
    import dram_arb_pkg::*;
#(
    parameter int MAXWAIT = MAXWAIT_DEFAULT
) (
    input  logic clock,
    input  logic nreset,
    input  logic h_req,
    input  logic h_gnt,
    output logic expired
);

    localparam logic [WAITCNT_W-1:0] WAIT_LIMIT = WAITCNT_W'(MAXWAIT);

    logic [WAITCNT_W-1:0] waitcnt;
    logic [WAITCNT_W-1:0] waitcnt_next;

    always_comb begin
        waitcnt_next = waitcnt;
        if (!h_req || h_gnt) begin
            waitcnt_next = '0;
        end else if (waitcnt != WAIT_LIMIT) begin
            waitcnt_next = waitcnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            waitcnt <= '0;
        end else begin
            waitcnt <= waitcnt_next;
        end
    end

    assign expired = (waitcnt == WAIT_LIMIT);

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port data RAM between the core (default priority) and the host/DMA port,
// with a starvation counter that bounds how long the host can be locked out.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 12,
    parameter int DATAWIDTH = 32,
    parameter int MAXWAIT   = MAXWAIT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 c_req,
    input  logic                 c_we,
    input  logic [ADDRWIDTH-1:0] c_addr,
    input  logic [DATAWIDTH-1:0] c_wdata,
    output logic                 c_gnt,
    output logic                 c_stall,
    output logic                 c_rvalid,
    output logic [DATAWIDTH-1:0] c_rdata,
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic [ADDRWIDTH-1:0] h_addr,
    input  logic [DATAWIDTH-1:0] h_wdata,
    output logic                 h_gnt,
    output logic                 h_rvalid,
    output logic [DATAWIDTH-1:0] h_rdata,
    output logic                 m_en,
    output logic                 m_we,
    output logic [ADDRWIDTH-1:0] m_addr,
    output logic [DATAWIDTH-1:0] m_wdata,
    input  logic [DATAWIDTH-1:0] m_rdata
);

    logic expired;
    rsp_t rsp_state;
    rsp_t rsp_next;

    arb_starve_counter #(
        .MAXWAIT (MAXWAIT)
    ) u_starve (
        .clock   (clock),
        .nreset  (nreset),
        .h_req   (h_req),
        .h_gnt   (h_gnt),
        .expired (expired)
    );

    // Grants are masked by nreset so the RAM sees no access while reset is held.
    assign h_gnt   = nreset & h_req & (~c_req | expired);
    assign c_gnt   = nreset & c_req & ~h_gnt;
    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (h_gnt) begin
            m_en    = 1'b1;
            m_we    = h_we;
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end else if (c_gnt) begin
            m_en    = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end
    end

    always_comb begin
        rsp_next = RSP_NONE;
        if (c_gnt && !c_we) begin
            rsp_next = RSP_CORE;
        end else if (h_gnt && !h_we) begin
            rsp_next = RSP_HOST;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rsp_state <= RSP_NONE;
        end else begin
            rsp_state <= rsp_next;
        end
    end

    // Response data is gated so an idle port never sees stale RAM output.
    assign c_rvalid = (rsp_state == RSP_CORE);
    assign h_rvalid = (rsp_state == RSP_HOST);
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign h_rdata  = h_rvalid ? m_rdata : '0;

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Arbiter that shares the single-port data RAM of `riscv32s` between the core load/store port and a host/DMA port (JPEG input load and output readback). It sits between `riscvcore`, the host interface and `ram`. The core has default priority. A starvation counter guarantees the host gets an access within bounded time, and the block stalls the core while the host owns the RAM. It replaces the direct core-to-RAM connection inside `riscv32s`.

## Interface
- `ADDRWIDTH`, 12, RAM word-address width (depth = 2**ADDRWIDTH words)
- `DATAWIDTH`, 32, data word width
- `MAXWAIT`, 4, cycles a blocked host request waits before it gets priority (1..15)

- `clock`  in  1  single clock, rising edge
- `nreset`  in  1  asynchronous, active-low reset
- `c_req` / `c_we`  in  1/1  core access request / write enable
- `c_addr` / `c_wdata`  in  ADDRWIDTH/DATAWIDTH  core word address / write data
- `c_gnt`  out  1  core access accepted this cycle
- `c_stall`  out  1  `c_req & ~c_gnt`; holds the core pipeline
- `c_rvalid` / `c_rdata`  out  1/DATAWIDTH  core read response
- `h_req` / `h_we` / `h_addr` / `h_wdata`  in  1/1/ADDRWIDTH/DATAWIDTH  host request
- `h_gnt`  out  1  host access accepted this cycle
- `h_rvalid` / `h_rdata`  out  1/DATAWIDTH  host read response
- `m_en` / `m_we`  out  1/1  RAM enable / write enable
- `m_addr` / `m_wdata`  out  ADDRWIDTH/DATAWIDTH  RAM address / write data
- `m_rdata`  in  DATAWIDTH  RAM read data, valid 1 cycle after `m_en & ~m_we`

## Operation
- Grant is combinational from the current-cycle requests plus registered state. At most one grant per cycle.
- Priority rule:
  - Host wins if `h_req & (~c_req | waitcnt == MAXWAIT)`.
  - Otherwise the core wins if `c_req`.
  - No request: no grant, `m_en=0`.
- Winner's `we/addr/wdata` are muxed to `m_*` and `m_en=1` in the grant cycle. A requester holds its request fields stable until granted.
- `waitcnt` (4 bit):
  - Increments each cycle `h_req & ~h_gnt`, saturating at MAXWAIT.
  - Clears on `h_gnt` or when `h_req=0`.
- Response FSM `rsp_state`:
  - States: `RSP_NONE`, `RSP_CORE`, `RSP_HOST`.
  - Next state is `RSP_CORE`/`RSP_HOST` after a granted core/host read, else `RSP_NONE`.
  - Registered every cycle, no hold.
- `c_rvalid = (rsp_state==RSP_CORE)`, `h_rvalid = (rsp_state==RSP_HOST)`.
- `c_rdata`/`h_rdata` = `m_rdata` when the matching rvalid is set, else 0.
- Writes produce no rvalid. Write data is in RAM at the clock edge ending the grant cycle.

## Timing
- Reset: all grants, rvalids, `m_en`, `m_we` = 0; `m_addr`, `m_wdata`, `rdata` = 0; `waitcnt`=0; `rsp_state=RSP_NONE`. Effective asynchronously on `nreset` fall.
- Read latency: grant in cycle N, rvalid plus data in cycle N+1. Back-to-back reads give one response per cycle.
- Write latency: 0 cycles to accept, committed at end of cycle N. A read of the same address granted in N+1 returns the new data.
- Simultaneous requests with `waitcnt<MAXWAIT`: core granted, `c_stall=0`, host `waitcnt++`.
- Continuous core requests: the host is granted at most MAXWAIT+1 cycles after raising `h_req`. The core is stalled exactly that cycle.
- Reset asserted mid-read: the pending response is dropped, no rvalid after reset release.
- `h_req` dropped before grant: `waitcnt` clears next cycle, no access issued.
- `c_stall` is combinational; the core must not register the stall path twice.

## Structure
- Package `dram_arb_pkg`: `typedef enum logic [1:0] {RSP_NONE, RSP_CORE, RSP_HOST} rsp_t;` and default `MAXWAIT` constant.
- Sub-module `arb_starve_counter`: saturating wait counter, parameterised by MAXWAIT. It outputs `expired = (waitcnt==MAXWAIT)`.
- Top `dram_arbiter`: priority logic, RAM mux, response FSM. Target about 150–250 lines total.

## Test plan
- Core-only: write 100 to addr 0, then read addr 0 → `c_gnt=1` both cycles, `c_rvalid=1` with `c_rdata=100` one cycle after the read grant, `h_*` all 0.
- Host-only back-to-back reads of addr 5,6 (preloaded 55,66) → `h_rvalid` on consecutive cycles with 55 then 66.
- Core requests every cycle, host raises `h_req` at cycle 0 with MAXWAIT=4 → core granted cycles 0–3, host granted cycle 4 with `c_stall=1` there, `waitcnt` back to 0 in cycle 5.
- Simultaneous core write addr 7=1, host read addr 7 (old 9) → core first, host granted next cycle reads 1.
- `nreset` pulsed low the cycle after a core read grant → no `c_rvalid`, all outputs 0, `rsp_state=RSP_NONE`.
- Host raises then drops `h_req` after 2 blocked cycles → no host access, `waitcnt`=0, `m_en` driven only by core.
